// File: rtl/uart_rx_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM encoding, field widths,
// default sync marker and the checksum rule.
package uart_rx_frame_parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CHK_W             = 8;
    localparam int         LEN_W             = 4;

    // A frame is good when the running sum plus the CHK byte wraps to zero.
    function automatic logic checksum_ok(input logic [CHK_W-1:0] sum,
                                         input logic [CHK_W-1:0] chk);
        logic [CHK_W-1:0] total;
        total = sum + chk;
        return total == '0;
    endfunction

endpackage

// File: rtl/uart_rx_frame_parser_timeout.sv
// Inter-byte watchdog: counts idle clocks while enabled and flags expiry on
// the last allowed idle cycle. Clearing restarts the count from zero.
module uart_rx_frame_parser_timeout #(
    parameter int c_TIMEOUT_CYCLES = 4340
) (
    input  logic i_CLK,
    input  logic i_RESET,
    input  logic i_CLEAR,
    input  logic i_ENABLE,
    output logic o_EXPIRED
);

    localparam int              CNT_W = $clog2(c_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(c_TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Elapsed-idle counter; parks at LAST so it can never wrap back to zero.
    always_ff @(posedge i_CLK) begin
        if (i_RESET || i_CLEAR) begin
            count <= '0;
        end else if (i_ENABLE && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_EXPIRED = i_ENABLE && (count == LAST);

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses SYNC/CMD/LEN/PAYLOAD/CHK frames from the UART receiver byte stream,
// publishes verified frames and pulses one error flag for malformed or
// stalled frames.
module uart_rx_frame_parser
    import uart_rx_frame_parser_pkg::*;
#(
    parameter int         c_MAX_PAYLOAD    = 8,
    parameter logic [7:0] c_SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         c_TIMEOUT_CYCLES = 4340
) (
    input  logic                       i_CLK,
    input  logic                       i_RESET,
    input  logic [7:0]                 i_RX_DATA,
    input  logic                       i_RX_DATA_VALID,
    output logic [7:0]                 o_CMD,
    output logic [8*c_MAX_PAYLOAD-1:0] o_PAYLOAD,
    output logic [LEN_W-1:0]           o_PAYLOAD_LEN,
    output logic                       o_FRAME_VALID,
    output logic                       o_ERR_CHECKSUM,
    output logic                       o_ERR_LENGTH,
    output logic                       o_ERR_TIMEOUT,
    output logic                       o_BUSY
);

    localparam int         PL_W      = 8 * c_MAX_PAYLOAD;
    localparam logic [7:0] MAX_LEN_B = 8'(c_MAX_PAYLOAD);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         cmd_stage;
    logic [LEN_W-1:0]   len_stage;
    logic [LEN_W-1:0]   idx;
    logic [CHK_W-1:0]   sum;
    logic [PL_W-1:0]    pl_stage;
    logic               expired;
    logic               timer_clear;
    logic               timer_enable;
    logic               frame_ok_p0;
    logic               chk_err_p0;
    logic               len_err_p0;
    logic               tmo_p0;

    // Staging may still hold bytes of an earlier, longer frame; mask them off.
    function automatic logic [PL_W-1:0] zero_fill(input logic [PL_W-1:0]  pl,
                                                  input logic [LEN_W-1:0] len);
        logic [PL_W-1:0] r;
        r = '0;
        for (int k = 0; k < c_MAX_PAYLOAD; k++) begin
            if (LEN_W'(k) < len) begin
                r[8*k +: 8] = pl[8*k +: 8];
            end
        end
        return r;
    endfunction

    // A strobe always wins over expiry, so the timer restarts on every byte.
    assign timer_clear  = i_RX_DATA_VALID || (state == S_IDLE);
    assign timer_enable = (state != S_IDLE);

    uart_rx_frame_parser_timeout #(
        .c_TIMEOUT_CYCLES (c_TIMEOUT_CYCLES)
    ) u_timeout (
        .i_CLK     (i_CLK),
        .i_RESET   (i_RESET),
        .i_CLEAR   (timer_clear),
        .i_ENABLE  (timer_enable),
        .o_EXPIRED (expired)
    );

    // FSM state register.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: advance only on strobes; a stall inside a frame aborts it.
    always_comb begin
        state_nxt = state;
        if (i_RX_DATA_VALID) begin
            case (state)
                S_IDLE:    if (i_RX_DATA == c_SYNC_BYTE) state_nxt = S_CMD;
                S_CMD:     state_nxt = S_LEN;
                S_LEN: begin
                    if (i_RX_DATA > MAX_LEN_B)  state_nxt = S_IDLE;
                    else if (i_RX_DATA == 8'd0) state_nxt = S_CHK;
                    else                        state_nxt = S_PAYLOAD;
                end
                S_PAYLOAD: if (idx == len_stage - LEN_W'(1)) state_nxt = S_CHK;
                S_CHK:     state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end else if (expired) begin
            state_nxt = S_IDLE;
        end
    end

    // Output decode: at most one of these can be true because each needs a distinct state or no strobe.
    always_comb begin
        frame_ok_p0 = 1'b0;
        chk_err_p0  = 1'b0;
        len_err_p0  = 1'b0;
        tmo_p0      = 1'b0;
        if (i_RX_DATA_VALID) begin
            if (state == S_CHK) begin
                frame_ok_p0 = checksum_ok(sum, i_RX_DATA);
                chk_err_p0  = !checksum_ok(sum, i_RX_DATA);
            end
            if (state == S_LEN) begin
                len_err_p0 = (i_RX_DATA > MAX_LEN_B);
            end
        end else begin
            tmo_p0 = expired;
        end
    end

    // Staging buffer, payload index and running checksum.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            cmd_stage <= '0;
            len_stage <= '0;
            idx       <= '0;
            sum       <= '0;
            pl_stage  <= '0;
        end else if (i_RX_DATA_VALID) begin
            case (state)
                S_CMD: begin
                    cmd_stage <= i_RX_DATA;
                    sum       <= i_RX_DATA;
                end
                S_LEN: begin
                    len_stage <= i_RX_DATA[LEN_W-1:0];
                    sum       <= sum + i_RX_DATA;
                    idx       <= '0;
                end
                S_PAYLOAD: begin
                    for (int k = 0; k < c_MAX_PAYLOAD; k++) begin
                        if (idx == LEN_W'(k)) begin
                            pl_stage[8*k +: 8] <= i_RX_DATA;
                        end
                    end
                    sum <= sum + i_RX_DATA;
                    idx <= idx + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered status pulses; published fields change only on a good frame.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            o_CMD          <= '0;
            o_PAYLOAD      <= '0;
            o_PAYLOAD_LEN  <= '0;
            o_FRAME_VALID  <= 1'b0;
            o_ERR_CHECKSUM <= 1'b0;
            o_ERR_LENGTH   <= 1'b0;
            o_ERR_TIMEOUT  <= 1'b0;
        end else begin
            o_FRAME_VALID  <= frame_ok_p0;
            o_ERR_CHECKSUM <= chk_err_p0;
            o_ERR_LENGTH   <= len_err_p0;
            o_ERR_TIMEOUT  <= tmo_p0;
            if (frame_ok_p0) begin
                o_CMD         <= cmd_stage;
                o_PAYLOAD_LEN <= len_stage;
                o_PAYLOAD     <= zero_fill(pl_stage, len_stage);
            end
        end
    end

    assign o_BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: frames are issued with random
// content and gaps, expected events are queued by a frame-level model and a
// monitor checks every output pulse against the queue.
module tb_uart_rx_frame_parser;

    localparam int  MAX = 8;
    localparam int  T   = 4340;
    localparam time PER = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = '0;
    logic             rx_vld = 1'b0;
    logic [7:0]       o_cmd;
    logic [8*MAX-1:0] o_pl;
    logic [3:0]       o_len;
    logic             o_fv, o_ec, o_el, o_et, o_busy;

    typedef struct {
        int               kind;   // 0 good, 1 checksum, 2 length, 3 timeout
        time              t;      // clock edge that should launch the pulse
        logic [7:0]       cmd;
        logic [3:0]       len;
        logic [8*MAX-1:0] pl;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [7:0]       pl [16];
    logic [7:0]       lg_cmd = '0;
    logic [3:0]       lg_len = '0;
    logic [8*MAX-1:0] lg_pl = '0;

    uart_rx_frame_parser #(
        .c_MAX_PAYLOAD    (MAX),
        .c_SYNC_BYTE      (8'hA5),
        .c_TIMEOUT_CYCLES (T)
    ) dut (
        .i_CLK           (clk),
        .i_RESET         (rst),
        .i_RX_DATA       (rx_data),
        .i_RX_DATA_VALID (rx_vld),
        .o_CMD           (o_cmd),
        .o_PAYLOAD       (o_pl),
        .o_PAYLOAD_LEN   (o_len),
        .o_FRAME_VALID   (o_fv),
        .o_ERR_CHECKSUM  (o_ec),
        .o_ERR_LENGTH    (o_el),
        .o_ERR_TIMEOUT   (o_et),
        .o_BUSY          (o_busy)
    );

    always #(PER/2) clk = ~clk;

    initial begin
        #(PER * 60000);
        $display("FAIL watchdog: got no finish, required finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Strobe one byte; returns just after the edge that samples it.
    task automatic send_byte(input logic [7:0] b, output time t);
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge clk);
        t = $time;
        #1 rx_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int kind, input time t);
        exp_t e;
        e.kind = kind;
        e.t    = t;
        e.cmd  = lg_cmd;
        e.len  = lg_len;
        e.pl   = lg_pl;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] calc_chk(input logic [7:0] cmd, input logic [7:0] len);
        int s;
        s = cmd + len;
        for (int k = 0; k < len && k < 16; k++) s += pl[k];
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Frame-level model: length rule first, then the modulo-256 sum rule.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                              input logic [7:0] chk, input int gmax);
        time t;
        int  s;
        send_byte(8'hA5, t);
        check("busy_in_frame", o_busy, 1'b1);
        idle($urandom_range(0, gmax));
        send_byte(cmd, t);
        idle($urandom_range(0, gmax));
        send_byte(len, t);
        if (len > MAX) begin
            push(2, t);
            idle($urandom_range(0, gmax));
            return;
        end
        idle($urandom_range(0, gmax));
        s = cmd + len + chk;
        for (int k = 0; k < len; k++) begin
            send_byte(pl[k], t);
            s += pl[k];
            idle($urandom_range(0, gmax));
        end
        send_byte(chk, t);
        if (s % 256 == 0) begin
            lg_cmd = cmd;
            lg_len = len[3:0];
            for (int k = 0; k < MAX; k++) lg_pl[8*k +: 8] = (k < len) ? pl[k] : 8'h00;
            push(0, t);
        end else begin
            push(1, t);
        end
        idle($urandom_range(0, gmax));
    endtask

    // Monitor: every pulse must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        int   npulse;
        int   act_kind;
        exp_t e;
        npulse = int'(o_fv) + int'(o_ec) + int'(o_el) + int'(o_et);
        if (npulse > 1) check("one_hot_pulses", 128'(npulse), 128'd1);
        if (npulse >= 1) begin
            act_kind = o_fv ? 0 : o_ec ? 1 : o_el ? 2 : 3;
            if (sb.size() == 0) begin
                check("unexpected_pulse_kind", 128'(act_kind), 128'hFF);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 128'(act_kind), 128'(e.kind));
                check("pulse_time", 128'($time), 128'(e.t + PER/2));
                check("cmd", o_cmd, e.cmd);
                check("len", o_len, e.len);
                check("payload", o_pl, e.pl);
                if (act_kind == 3) check("busy_after_timeout", o_busy, 1'b0);
            end
        end
    end

    initial begin
        time t;
        logic [7:0] b;
        int kind;
        logic [7:0] cmd, len, chk;

        idle(3);
        check("rst_cmd", o_cmd, 8'h00);
        check("rst_payload", o_pl, '0);
        check("rst_len", o_len, 4'h0);
        check("rst_pulses", {o_fv, o_ec, o_el, o_et}, 4'b0000);
        check("rst_busy", o_busy, 1'b0);
        rst = 1'b0;
        idle(2);

        // Basic good frame, then same frame with a corrupted checksum.
        pl[0] = 8'h11; pl[1] = 8'h22;
        send_frame(8'h10, 8'h02, 8'hBB, 0);
        send_frame(8'h10, 8'h02, 8'hBC, 0);
        // Oversized LEN, then an empty-payload frame.
        send_frame(8'h20, 8'h09, 8'h00, 0);
        send_frame(8'h01, 8'h00, 8'hFF, 0);
        // Garbage followed by two back-to-back frames.
        send_byte(8'h00, t); send_byte(8'hFF, t); send_byte(8'h5A, t);
        pl[0] = 8'h11; pl[1] = 8'h22;
        send_frame(8'h10, 8'h02, 8'hBB, 0);
        send_frame(8'h10, 8'h02, 8'hBB, 0);
        // SYNC value inside a frame is ordinary data; full-length payload.
        for (int k = 0; k < MAX; k++) pl[k] = (k == 0) ? 8'hA5 : 8'(k * 17);
        send_frame(8'hA5, 8'(MAX), calc_chk(8'hA5, 8'(MAX)), 1);

        // Stall inside a frame.
        send_byte(8'hA5, t); send_byte(8'h30, t); send_byte(8'h03, t); send_byte(8'h01, t);
        push(3, t + T * PER);
        idle(T + 2);
        check("busy_idle_after_timeout", o_busy, 1'b0);

        // Byte arriving exactly on the expiry cycle keeps the frame alive.
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        send_byte(8'hA5, t); send_byte(8'h30, t); send_byte(8'h03, t); send_byte(8'h01, t);
        idle(T - 1);
        send_byte(8'h02, t);
        send_byte(8'h03, t);
        send_byte(calc_chk(8'h30, 8'h03), t);
        lg_cmd = 8'h30; lg_len = 4'd3;
        lg_pl = '0;
        for (int k = 0; k < 3; k++) lg_pl[8*k +: 8] = pl[k];
        push(0, t);
        idle(2);

        // Reset in the middle of the payload discards the frame silently.
        send_byte(8'hA5, t); send_byte(8'h40, t); send_byte(8'h04, t);
        send_byte(8'h11, t); send_byte(8'h22, t);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_cmd", o_cmd, 8'h00);
        check("midrst_payload", o_pl, '0);
        check("midrst_len", o_len, 4'h0);
        check("midrst_busy", o_busy, 1'b0);
        rst = 1'b0;
        lg_cmd = '0; lg_len = '0; lg_pl = '0;
        pl[0] = 8'h11; pl[1] = 8'h22;
        send_frame(8'h10, 8'h02, 8'hBB, 0);

        // Randomized frames.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            cmd  = 8'($urandom);
            for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
            len = (kind == 2) ? 8'($urandom_range(MAX + 1, 255)) : 8'($urandom_range(0, MAX));
            chk = calc_chk(cmd, len);
            if (kind == 1) chk = chk + 8'($urandom_range(1, 255));
            if (kind == 3) begin
                for (int g = 0; g < 3; g++) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h00;
                    send_byte(b, t);
                end
            end
            send_frame(cmd, len, chk, 3);
        end

        idle(5);
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
